// File: rtl/operand_fetch_stage.sv
// Operand fetch stage between decode and execute.
// Drives the register-file read ports, resolves both operands (register file,
// writeback bypass or immediate) and captures them into a valid/ready output
// slot. A per-register scoreboard counts outstanding writes and stalls decode
// on read-after-write hazards.
//
// Ports:
//   clk, rst                   clock (rising edge), async active-high reset
//   in_valid/in_ready          decode handshake
//   in_a1, in_a2, in_use_imm,
//   in_imm, in_dst, in_wr_en,
//   in_op                      decoded instruction fields
//   rf_a1, rf_a2 / rf_rd1,
//   rf_rd2                     register-file read ports
//   wb_we, wb_a3, wb_wd        copy of the register-file write port
//   flush                      squash the instruction held in the output slot
//   out_valid/out_ready        execute handshake
//   out_op1, out_op2, out_dst,
//   out_wr_en, out_op          resolved operands and pass-through fields
module operand_fetch_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREG   = 32,
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_a1,
  input  logic [ADDR_W-1:0] in_a2,
  input  logic              in_use_imm,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [ADDR_W-1:0] in_dst,
  input  logic              in_wr_en,
  input  logic [OP_W-1:0]   in_op,
  output logic [ADDR_W-1:0] rf_a1,
  output logic [ADDR_W-1:0] rf_a2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_a3,
  input  logic [DATA_W-1:0] wb_wd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op1,
  output logic [DATA_W-1:0] out_op2,
  output logic [ADDR_W-1:0] out_dst,
  output logic              out_wr_en,
  output logic [OP_W-1:0]   out_op
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntTwo = CNT_W'(2);

  logic [CNT_W-1:0]  cnt_q [NREG];
  logic [CNT_W-1:0]  cnt_d [NREG];
  logic [NREG-1:0]   inc, dec_wb, dec_fl;

  logic              valid_q;
  logic [DATA_W-1:0] op1_q, op2_q;
  logic [ADDR_W-1:0] dst_q;
  logic              wr_en_q;
  logic [OP_W-1:0]   op_q;

  logic              slot_free, hz1, hz2, dst_full, issue;
  logic [DATA_W-1:0] opnd1, opnd2;

  assign rf_a1 = in_a1;
  assign rf_a2 = in_a2;

  assign slot_free = !valid_q || out_ready;

  // A pending write can be bypassed only when this cycle's writeback retires
  // the sole outstanding write to that register.
  always_comb begin
    hz1   = 1'b0;
    opnd1 = rf_rd1;
    if (cnt_q[in_a1] != '0) begin
      if (cnt_q[in_a1] == CntOne && wb_we && wb_a3 == in_a1) opnd1 = wb_wd;
      else hz1 = 1'b1;
    end
  end

  always_comb begin
    hz2   = 1'b0;
    opnd2 = rf_rd2;
    if (in_use_imm) begin
      opnd2 = in_imm;
    end else if (cnt_q[in_a2] != '0) begin
      if (cnt_q[in_a2] == CntOne && wb_we && wb_a3 == in_a2) opnd2 = wb_wd;
      else hz2 = 1'b1;
    end
  end

  // A full counter frees one slot when the same register is written back this
  // cycle, so the new writer may issue alongside that writeback.
  assign dst_full = in_wr_en && cnt_q[in_dst] == CntMax && !(wb_we && wb_a3 == in_dst);

  assign in_ready = slot_free && !hz1 && !hz2 && !dst_full && !flush;
  assign issue    = in_valid && in_ready;

  // Scoreboard next state; decrements saturate at zero.
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      inc[r]    = issue && in_wr_en && (in_dst == ADDR_W'(r));
      dec_wb[r] = wb_we && (wb_a3 == ADDR_W'(r));
      dec_fl[r] = flush && valid_q && wr_en_q && (dst_q == ADDR_W'(r));
      cnt_d[r]  = cnt_q[r];
      if (inc[r]) begin
        if (!dec_wb[r] && !dec_fl[r]) begin
          cnt_d[r] = cnt_q[r] + CntOne;
        end else if (dec_wb[r] && dec_fl[r]) begin
          cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CntOne : '0;
        end
      end else if (dec_wb[r] && dec_fl[r]) begin
        cnt_d[r] = (cnt_q[r] > CntOne) ? cnt_q[r] - CntTwo : '0;
      end else if (dec_wb[r] || dec_fl[r]) begin
        cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CntOne : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      dst_q   <= '0;
      wr_en_q <= 1'b0;
      op_q    <= '0;
      for (int unsigned r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (issue) begin
        valid_q <= 1'b1;
        op1_q   <= opnd1;
        op2_q   <= opnd2;
        dst_q   <= in_dst;
        wr_en_q <= in_wr_en;
        op_q    <= in_op;
      end else if (flush || out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_op1   = op1_q;
  assign out_op2   = op2_q;
  assign out_dst   = dst_q;
  assign out_wr_en = wr_en_q;
  assign out_op    = op_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_use_imm, in_wr_en;
  logic [4:0]  in_a1, in_a2, in_dst, rf_a1, rf_a2, wb_a3, out_dst;
  logic [31:0] in_imm, rf_rd1, rf_rd2, wb_wd, out_op1, out_op2;
  logic [3:0]  in_op, out_op;
  logic        wb_we, flush, out_valid, out_ready, out_wr_en;

  int checks = 0;
  int errors = 0;

  // Register file and reference model state
  logic [31:0] rf [32];
  int          m_cnt [32];
  logic        m_valid;
  logic [31:0] m_op1, m_op2;
  logic [4:0]  m_dst;
  logic        m_wr_en;
  logic [3:0]  m_op;

  assign rf_rd1 = rf[rf_a1];
  assign rf_rd2 = rf[rf_a2];

  wire [74:0] dut_bus = {out_valid, out_op1, out_op2, out_dst, out_wr_en, out_op};

  always #5 clk = ~clk;

  operand_fetch_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a1(in_a1), .in_a2(in_a2), .in_use_imm(in_use_imm), .in_imm(in_imm),
    .in_dst(in_dst), .in_wr_en(in_wr_en), .in_op(in_op),
    .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_we(wb_we), .wb_a3(wb_a3), .wb_wd(wb_wd),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2),
    .out_dst(out_dst), .out_wr_en(out_wr_en), .out_op(out_op)
  );

  function automatic logic [74:0] exp_bus();
    return {m_valid, m_op1, m_op2, m_dst, m_wr_en, m_op};
  endfunction

  function automatic logic src_hz(input logic [4:0] s);
    if (m_cnt[s] == 0) return 1'b0;
    if (m_cnt[s] == 1 && wb_we && wb_a3 == s) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] src_val(input logic [4:0] s);
    return (m_cnt[s] == 0) ? rf[s] : wb_wd;
  endfunction

  function automatic logic exp_ready();
    logic full, slot, hz;
    full = in_wr_en && m_cnt[in_dst] == 3 && !(wb_we && wb_a3 == in_dst);
    slot = !m_valid || out_ready;
    hz   = src_hz(in_a1) || (!in_use_imm && src_hz(in_a2));
    return slot && !hz && !full && !flush;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_op1 = '0; m_op2 = '0; m_dst = '0; m_wr_en = 1'b0; m_op = '0;
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_a1 = '0; in_a2 = '0; in_use_imm = 1'b0; in_imm = '0;
    in_dst = '0; in_wr_en = 1'b0; in_op = '0;
    wb_we = 1'b0; wb_a3 = '0; wb_wd = '0; flush = 1'b0; out_ready = 1'b1;
  endtask

  // Advance one clock; the model computes its next state from the inputs
  // held during the cycle and commits it just after the edge.
  task automatic tick();
    logic        iss, nv;
    logic [31:0] n1, n2;
    int          nc [32];
    iss = in_valid && exp_ready();
    for (int r = 0; r < 32; r++) begin
      nc[r] = m_cnt[r] + ((iss && in_wr_en && in_dst == r) ? 1 : 0)
            - ((wb_we && wb_a3 == r) ? 1 : 0)
            - ((flush && m_valid && m_wr_en && m_dst == r) ? 1 : 0);
      if (nc[r] < 0) nc[r] = 0;
    end
    n1 = src_val(in_a1);
    n2 = in_use_imm ? in_imm : src_val(in_a2);
    nv = iss ? 1'b1 : ((flush || out_ready) ? 1'b0 : m_valid);
    @(posedge clk);
    #1;
    if (iss) begin
      m_op1 = n1; m_op2 = n2; m_dst = in_dst; m_wr_en = in_wr_en; m_op = in_op;
    end
    m_valid = nv;
    for (int r = 0; r < 32; r++) m_cnt[r] = nc[r];
    if (wb_we) rf[wb_a3] = wb_wd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    model_reset();
    #1;
    checks++;
    if (dut_bus !== exp_bus()) begin
      errors++; $display("FAIL reset_init: outputs=%h expected %h", dut_bus, exp_bus());
    end
    @(posedge clk); #1;
    rst = 1'b0;
    // Two writers of r3 leave cnt[3]=2 and a full output slot
    in_valid = 1'b1; in_use_imm = 1'b1; in_wr_en = 1'b1; in_dst = 5'd3; in_op = 4'h6;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL reset_prep_ready: in_ready=%b expected 1", in_ready);
      end
      tick();
    end
    idle();
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dut_bus !== exp_bus()) begin
      errors++; $display("FAIL reset_async: outputs=%h expected %h", dut_bus, exp_bus());
    end
    in_valid = 1'b1; in_a1 = 5'd3; in_use_imm = 1'b1; in_imm = 32'h11;
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_cnt_clear: in_ready=%b expected 1", in_ready);
    end
    tick();
    checks++;
    if (dut_bus !== exp_bus() || out_op1 !== rf[3]) begin
      errors++; $display("FAIL reset_reader: outputs=%h expected %h", dut_bus, exp_bus());
    end
    idle();
    tick();
  endtask

  task automatic test_imm();
    idle();
    rf[9] = 32'h0000_0020;
    in_valid = 1'b1; in_a1 = 5'd9; in_use_imm = 1'b1; in_imm = 32'h4; in_op = 4'h2;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL imm_ready: in_ready=%b expected 1", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_op1 !== 32'h20 || out_op2 !== 32'h4 || dut_bus !== exp_bus()) begin
      errors++; $display("FAIL imm_issue: outputs=%h expected %h", dut_bus, exp_bus());
    end
    idle();
    tick();
  endtask

  task automatic test_raw_bypass();
    idle();
    in_valid = 1'b1; in_use_imm = 1'b1; in_wr_en = 1'b1; in_dst = 5'd3;
    tick();
    in_wr_en = 1'b0; in_dst = 5'd0; in_a1 = 5'd3; in_op = 4'h9;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL raw_stall: in_ready=%b expected 0", in_ready);
      end
      tick();
    end
    wb_we = 1'b1; wb_a3 = 5'd3; wb_wd = 32'h1234;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL raw_bypass_ready: in_ready=%b expected 1", in_ready);
    end
    tick();
    wb_we = 1'b0;
    checks++;
    if (out_op1 !== 32'h1234 || dut_bus !== exp_bus()) begin
      errors++; $display("FAIL raw_bypass_data: outputs=%h expected %h", dut_bus, exp_bus());
    end
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL raw_cnt_clear: in_ready=%b expected 1", in_ready);
    end
    idle();
    tick();
  endtask

  task automatic test_backpressure();
    logic [74:0] held;
    idle();
    in_valid = 1'b1; in_a1 = 5'd1; in_a2 = 5'd2; in_op = 4'hA;
    tick();
    held = exp_bus();
    out_ready = 1'b0; in_a1 = 5'd4; in_a2 = 5'd6; in_op = 4'hB;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || dut_bus !== held) begin
        errors++;
        $display("FAIL hold_cycle%0d: in_ready=%b outputs=%h expected 0 / %h", i, in_ready, dut_bus, held);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL hold_release: in_ready=%b expected 1", in_ready);
    end
    tick();
    checks++;
    if (dut_bus !== exp_bus() || out_op1 !== rf[4] || out_op2 !== rf[6]) begin
      errors++; $display("FAIL hold_issue: outputs=%h expected %h", dut_bus, exp_bus());
    end
    idle();
    tick();
  endtask

  task automatic test_dst_full();
    idle();
    in_valid = 1'b1; in_use_imm = 1'b1; in_wr_en = 1'b1; in_dst = 5'd5; in_op = 4'h5;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL full_fill%0d: in_ready=%b expected 1", i, in_ready);
      end
      tick();
    end
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL full_stall: in_ready=%b expected 0", in_ready);
    end
    tick();
    wb_we = 1'b1; wb_a3 = 5'd5; wb_wd = 32'h55;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL full_wb_issue: in_ready=%b expected 1", in_ready);
    end
    tick();
    wb_we = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || m_cnt[5] != 3) begin
      errors++; $display("FAIL full_still3: in_ready=%b expected 0", in_ready);
    end
    in_valid = 1'b0; in_wr_en = 1'b0;
    wb_we = 1'b1;
    for (int i = 0; i < 8 && m_cnt[5] > 0; i++) tick();
    idle();
    tick();
  endtask

  task automatic test_flush();
    idle();
    in_valid = 1'b1; in_use_imm = 1'b1; in_wr_en = 1'b1; in_dst = 5'd7; in_op = 4'h7;
    tick();
    in_wr_en = 1'b0; in_dst = 5'd0; in_a1 = 5'd7; in_op = 4'h8;
    out_ready = 1'b0; flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready: in_ready=%b expected 0", in_ready);
    end
    tick();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || dut_bus !== exp_bus()) begin
      errors++; $display("FAIL flush_squash: outputs=%h expected %h", dut_bus, exp_bus());
    end
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_cnt_clear: in_ready=%b expected 1", in_ready);
    end
    tick();
    checks++;
    if (out_op1 !== rf[7] || dut_bus !== exp_bus()) begin
      errors++; $display("FAIL flush_reader: outputs=%h expected %h", dut_bus, exp_bus());
    end
    idle();
    tick();
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(3) != 0);
      in_a1      = 5'($urandom_range(7));
      in_a2      = 5'($urandom_range(7));
      in_use_imm = ($urandom_range(3) == 0);
      in_imm     = $urandom;
      in_dst     = 5'($urandom_range(7));
      in_wr_en   = ($urandom_range(2) != 0);
      in_op      = 4'($urandom);
      out_ready  = ($urandom_range(3) != 0);
      flush      = ($urandom_range(15) == 0);
      r          = $urandom_range(7);
      wb_a3      = 5'(r);
      wb_wd      = $urandom;
      wb_we      = (m_cnt[r] > 0) ? ($urandom_range(1) == 1) : ($urandom_range(15) == 0);
      #1;
      checks++;
      if (in_ready !== exp_ready() || dut_bus !== exp_bus()) begin
        errors++;
        $display("FAIL random_cycle%0d: in_ready=%b outputs=%h expected %b / %h",
                 i, in_ready, dut_bus, exp_ready(), exp_bus());
      end
      tick();
    end
    idle();
    #1;
    checks++;
    if (dut_bus !== exp_bus()) begin
      errors++; $display("FAIL random_final: outputs=%h expected %h", dut_bus, exp_bus());
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    test_reset();
    test_imm();
    test_raw_bypass();
    test_backpressure();
    test_dst_full();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
